// File: rtl/fifo_data_reader.sv
// Register-side drain for the sample FIFO: serves FIFO_DATA / FIFO_ENTRIES byte reads.
// Optional macro FIFO_AXIS_MARKER_EN enables the per-pop axis marker in bit 0 of each entry.
module fifo_data_reader #(
  parameter int unsigned DATA_WIDTH        = 24,
  parameter int unsigned DEPTH             = 16,
  parameter logic [7:0]  FIFO_DATA_ADDR    = 8'h11,
  parameter logic [7:0]  FIFO_ENTRIES_ADDR = 8'h05
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_rd_req,
  input  logic [7:0]            reg_rd_addr,
  input  logic                  reg_burst_end,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_reg_data,
  input  logic [DEPTH-1:0]      fifo_sample_num,
  output logic                  reg_fifo_read_en,
  output logic [7:0]            reg_rd_data,
  output logic                  reg_rd_valid,
  output logic                  busy
);

  localparam int unsigned IDX_W  = 2;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2,
    CAP  = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_byte_idx, w_byte_idx_nxt, w_idx_eff;
  logic [DATA_WIDTH-1:0] r_hold, w_hold_nxt;
  logic                  r_pend, w_pend_nxt;
  logic [BYTE_W-1:0]     r_pend_data, w_pend_data_nxt;
  logic                  r_read_en, w_read_en_nxt;
  logic [BYTE_W-1:0]     r_rd_data, w_rd_data_nxt;
  logic                  r_rd_valid, w_rd_valid_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  w_marker;
  logic [BYTE_W-1:0]     w_entries;
  logic                  w_data_hit, w_entries_hit;
  logic                  w_unused;

`ifdef FIFO_AXIS_MARKER_EN
  logic [1:0] r_axis_cnt, w_axis_cnt_nxt;
  assign w_marker = (r_axis_cnt == 2'd0);
`else
  assign w_marker = 1'b0;
`endif

  // Low nibble of the FIFO word is replaced by status; hold byte 0 is never re-read.
  assign w_unused = ^{fifo_reg_data[3:0], r_hold[DATA_WIDTH-1 -: BYTE_W]};

  assign w_data_hit    = reg_rd_req && (reg_rd_addr == FIFO_DATA_ADDR);
  assign w_entries_hit = reg_rd_req && (reg_rd_addr == FIFO_ENTRIES_ADDR);
  assign w_idx_eff     = reg_burst_end ? '0 : r_byte_idx;
  assign w_entries     = (32'(fifo_sample_num) > 32'd255) ? 8'hFF : BYTE_W'(fifo_sample_num);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_byte_idx  <= '0;
      r_hold      <= '0;
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_read_en   <= 1'b0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_busy      <= 1'b0;
`ifdef FIFO_AXIS_MARKER_EN
      r_axis_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_hold      <= w_hold_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_data <= w_pend_data_nxt;
      r_read_en   <= w_read_en_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_busy      <= w_busy_nxt;
`ifdef FIFO_AXIS_MARKER_EN
      r_axis_cnt  <= w_axis_cnt_nxt;
`endif
    end
  end

  // Next-state and registered-output logic; direct reads go through a one-cycle pending stage.
  always_comb begin
    w_state_nxt     = r_state;
    w_byte_idx_nxt  = w_idx_eff;
    w_hold_nxt      = r_hold;
    w_pend_nxt      = 1'b0;
    w_pend_data_nxt = r_pend_data;
    w_read_en_nxt   = 1'b0;
    w_rd_data_nxt   = r_rd_data;
    w_rd_valid_nxt  = 1'b0;
`ifdef FIFO_AXIS_MARKER_EN
    w_axis_cnt_nxt  = r_axis_cnt;
`endif

    if (r_pend) begin
      w_rd_data_nxt  = r_pend_data;
      w_rd_valid_nxt = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_data_hit) begin
          w_byte_idx_nxt = (w_idx_eff >= 2'd2) ? 2'd0 : w_idx_eff + 2'd1;
          case (w_idx_eff)
            2'd1: begin
              w_pend_nxt      = 1'b1;
              w_pend_data_nxt = r_hold[DATA_WIDTH-9 -: BYTE_W];
            end
            2'd2: begin
              w_pend_nxt      = 1'b1;
              w_pend_data_nxt = r_hold[DATA_WIDTH-17 -: BYTE_W];
            end
            default: begin
              if (fifo_empty) begin
                w_hold_nxt      = DATA_WIDTH'(2);
                w_pend_nxt      = 1'b1;
                w_pend_data_nxt = 8'h00;
              end else begin
                w_state_nxt   = POP;
                w_read_en_nxt = 1'b1;
              end
            end
          endcase
        end else if (w_entries_hit) begin
          w_pend_nxt      = 1'b1;
          w_pend_data_nxt = w_entries;
        end
      end
      POP:  w_state_nxt = WAIT;
      WAIT: w_state_nxt = CAP;
      CAP: begin
        w_hold_nxt     = {fifo_reg_data[DATA_WIDTH-1:4], 3'b000, w_marker};
        w_rd_data_nxt  = fifo_reg_data[DATA_WIDTH-1 -: BYTE_W];
        w_rd_valid_nxt = 1'b1;
        w_state_nxt    = IDLE;
`ifdef FIFO_AXIS_MARKER_EN
        w_axis_cnt_nxt = (r_axis_cnt == 2'd2) ? 2'd0 : r_axis_cnt + 2'd1;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign reg_fifo_read_en = r_read_en;
  assign reg_rd_data      = r_rd_data;
  assign reg_rd_valid     = r_rd_valid;
  assign busy             = r_busy;

endmodule

// File: tb/tb_fifo_data_reader.sv
// Directed bench for fifo_data_reader with a small edge-triggered FIFO model.
module tb_fifo_data_reader;
  localparam logic [7:0] A_DATA = 8'h11;
  localparam logic [7:0] A_ENT  = 8'h05;
`ifdef FIFO_AXIS_MARKER_EN
  localparam logic [7:0] MK = 8'h01;
`else
  localparam logic [7:0] MK = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_rd_req = 1'b0;
  logic [7:0]  reg_rd_addr = 8'h00;
  logic        reg_burst_end = 1'b0;
  logic        fifo_empty;
  logic [23:0] fifo_reg_data = 24'h0;
  logic [15:0] fifo_sample_num = 16'd16;
  logic        reg_fifo_read_en;
  logic [7:0]  reg_rd_data;
  logic        reg_rd_valid;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_data_reader #(
    .DATA_WIDTH(24), .DEPTH(16), .FIFO_DATA_ADDR(8'h11), .FIFO_ENTRIES_ADDR(8'h05)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reg_rd_req(reg_rd_req), .reg_rd_addr(reg_rd_addr),
    .reg_burst_end(reg_burst_end), .fifo_empty(fifo_empty), .fifo_reg_data(fifo_reg_data),
    .fifo_sample_num(fifo_sample_num), .reg_fifo_read_en(reg_fifo_read_en),
    .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid), .busy(busy)
  );

  // FIFO model: pop registered on the read-strobe rising edge, data register loaded one cycle later.
  logic [23:0] mem [0:15];
  int   wr_ptr = 0, rd_ptr = 0, cnt = 0;
  logic en_d = 1'b0, pop_q = 1'b0;
  logic push_v = 1'b0;
  logic [23:0] push_d = 24'h0;
  int   pops = 0, pw_err = 0, vcnt = 0;

  assign fifo_empty = (cnt == 0);

  always @(posedge clk) begin
    en_d  <= reg_fifo_read_en;
    pop_q <= reg_fifo_read_en & ~en_d;
    if (reg_fifo_read_en && !en_d) pops <= pops + 1;
    if (reg_fifo_read_en && en_d) pw_err <= pw_err + 1;
    if (reg_rd_valid) vcnt <= vcnt + 1;
    cnt <= cnt + (push_v ? 1 : 0) - ((pop_q && cnt > 0) ? 1 : 0);
    if (push_v) begin
      mem[wr_ptr] <= push_d;
      wr_ptr <= (wr_ptr + 1) % 16;
    end
    if (pop_q && cnt > 0) begin
      fifo_reg_data <= mem[rd_ptr];
      rd_ptr <= (rd_ptr + 1) % 16;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [23:0] d);
    @(negedge clk);
    push_v = 1'b1;
    push_d = d;
    @(negedge clk);
    push_v = 1'b0;
  endtask

  task automatic pulse_burst_end();
    @(negedge clk);
    reg_burst_end = 1'b1;
    @(negedge clk);
    reg_burst_end = 1'b0;
  endtask

  // One read strobe; watches 6 cycles after the sampling edge for the returned byte.
  task automatic do_read(input logic [7:0] addr, input logic be, output logic got,
                         output logic [7:0] data, output int lat, output int pd);
    int p0;
    p0 = pops;
    got = 1'b0; data = 8'h00; lat = 0;
    @(negedge clk);
    reg_rd_req = 1'b1; reg_rd_addr = addr; reg_burst_end = be;
    @(negedge clk);
    reg_rd_req = 1'b0; reg_burst_end = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (reg_rd_valid && !got) begin
        got = 1'b1; data = reg_rd_data; lat = k;
      end
    end
    pd = pops - p0;
  endtask

  task automatic read_chk(input string nm, input logic [7:0] exp_d, input int exp_lat, input int exp_p);
    logic g; logic [7:0] d; int l, p;
    do_read(A_DATA, 1'b0, g, d, l, p);
    chk({nm, "_valid"}, 32'(g), 32'd1);
    chk({nm, "_data"}, 32'(d), 32'(exp_d));
    chk({nm, "_lat"}, 32'(l), 32'(exp_lat));
    chk({nm, "_pops"}, 32'(p), 32'(exp_p));
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic        be;
    logic [15:0] num;
    logic        vld;
    logic [7:0]  data;
    int          lat;
    int          pops;
  } vec_t;

  vec_t tv [27];

  initial begin
    logic g; logic [7:0] d; int l, p, v0, p0;

    tv[0]  = '{A_DATA, 1'b0, 16'd16,   1'b1, 8'hAB,      3, 1};
    tv[1]  = '{A_DATA, 1'b0, 16'd16,   1'b1, 8'hCD,      1, 0};
    tv[2]  = '{A_DATA, 1'b0, 16'd16,   1'b1, 8'hE0 | MK, 1, 0};
    tv[3]  = '{A_ENT,  1'b0, 16'd16,   1'b1, 8'h10,      1, 0};
    tv[4]  = '{A_DATA, 1'b0, 16'd16,   1'b1, 8'h12,      3, 1};
    tv[5]  = '{A_ENT,  1'b0, 16'd16,   1'b1, 8'h10,      1, 0};
    tv[6]  = '{A_DATA, 1'b0, 16'd16,   1'b1, 8'h34,      1, 0};
    tv[7]  = '{A_DATA, 1'b0, 16'd16,   1'b1, 8'h50,      1, 0};
    tv[8]  = '{8'h22,  1'b0, 16'd16,   1'b0, 8'h00,      0, 0};
    tv[9]  = '{A_DATA, 1'b0, 16'd16,   1'b1, 8'h78,      3, 1};
    tv[10] = '{A_DATA, 1'b0, 16'd16,   1'b1, 8'h9A,      1, 0};
    tv[11] = '{A_DATA, 1'b0, 16'd16,   1'b1, 8'hB0,      1, 0};
    tv[12] = '{A_DATA, 1'b0, 16'd16,   1'b1, 8'hFE,      3, 1};
    tv[13] = '{A_DATA, 1'b0, 16'd16,   1'b1, 8'hDC,      1, 0};
    tv[14] = '{A_DATA, 1'b1, 16'd16,   1'b1, 8'h24,      3, 1};
    tv[15] = '{A_DATA, 1'b0, 16'd16,   1'b1, 8'h68,      1, 0};
    tv[16] = '{A_DATA, 1'b0, 16'd16,   1'b1, 8'hA0,      1, 0};
    tv[17] = '{A_DATA, 1'b0, 16'd0,    1'b1, 8'h00,      1, 0};
    tv[18] = '{A_DATA, 1'b0, 16'd0,    1'b1, 8'h00,      1, 0};
    tv[19] = '{A_DATA, 1'b0, 16'd0,    1'b1, 8'h02,      1, 0};
    tv[20] = '{A_ENT,  1'b0, 16'h0123, 1'b1, 8'hFF,      1, 0};
    tv[21] = '{A_ENT,  1'b0, 16'h00FF, 1'b1, 8'hFF,      1, 0};
    tv[22] = '{A_ENT,  1'b0, 16'h0100, 1'b1, 8'hFF,      1, 0};
    tv[23] = '{A_ENT,  1'b0, 16'h0000, 1'b1, 8'h00,      1, 0};
    tv[24] = '{A_DATA, 1'b0, 16'd0,    1'b1, 8'h00,      1, 0};
    tv[25] = '{A_DATA, 1'b0, 16'd0,    1'b1, 8'h00,      1, 0};
    tv[26] = '{A_DATA, 1'b0, 16'd0,    1'b1, 8'h02,      1, 0};

    repeat (3) @(negedge clk);
    chk("rst_read_en", 32'(reg_fifo_read_en), 32'd0);
    chk("rst_rd_data", 32'(reg_rd_data), 32'd0);
    chk("rst_rd_valid", 32'(reg_rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    push(24'hABCDEF); push(24'h123456); push(24'h789ABC); push(24'hFEDCB7); push(24'h2468AC);

    for (int i = 0; i < 27; i++) begin
      fifo_sample_num = tv[i].num;
      do_read(tv[i].addr, tv[i].be, g, d, l, p);
      chk($sformatf("v%0d_valid", i), 32'(g), 32'(tv[i].vld));
      if (tv[i].vld) begin
        chk($sformatf("v%0d_data", i), 32'(d), 32'(tv[i].data));
        chk($sformatf("v%0d_lat", i), 32'(l), 32'(tv[i].lat));
      end
      chk($sformatf("v%0d_pops", i), 32'(p), 32'(tv[i].pops));
    end

    // Burst end between bytes 1 and 2 restarts at byte 0 with a fresh pop.
    push(24'h3C5A96); push(24'hDEAD5F);
    read_chk("be_b0", 8'h3C, 3, 1);
    read_chk("be_b1", 8'h5A, 1, 0);
    pulse_burst_end();
    read_chk("be_new_b0", 8'hDE, 3, 1);
    read_chk("be_new_b1", 8'hAD, 1, 0);
    read_chk("be_new_b2", 8'h50 | MK, 1, 0);

    // Requests held during busy are dropped and do not advance the byte index.
    push(24'h0F1E2D);
    v0 = vcnt; p0 = pops;
    @(negedge clk);
    reg_rd_req = 1'b1; reg_rd_addr = A_DATA;
    repeat (3) @(negedge clk);
    reg_rd_req = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_valid_cnt", 32'(vcnt - v0), 32'd1);
    chk("busy_data", 32'(reg_rd_data), 32'h0F);
    chk("busy_pops", 32'(pops - p0), 32'd1);
    read_chk("busy_b1", 8'h1E, 1, 0);
    read_chk("busy_b2", 8'h20, 1, 0);

    // Burst end during WAIT: pop still returns its byte and index stays at 0.
    push(24'h55AA33); push(24'h778899);
    v0 = vcnt;
    @(negedge clk);
    reg_rd_req = 1'b1; reg_rd_addr = A_DATA;
    @(negedge clk);
    reg_rd_req = 1'b0;
    @(negedge clk);
    reg_burst_end = 1'b1;
    @(negedge clk);
    reg_burst_end = 1'b0;
    repeat (5) @(negedge clk);
    chk("bewait_valid_cnt", 32'(vcnt - v0), 32'd1);
    chk("bewait_data", 32'(reg_rd_data), 32'h55);
    read_chk("bewait_next_b0", 8'h77, 3, 1);
    read_chk("bewait_next_b1", 8'h88, 1, 0);
    read_chk("bewait_next_b2", 8'h90 | MK, 1, 0);

    // Reset while in WAIT aborts the read without a returned byte.
    push(24'h112233);
    @(negedge clk);
    reg_rd_req = 1'b1; reg_rd_addr = A_DATA;
    @(negedge clk);
    reg_rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read_en", 32'(reg_fifo_read_en), 32'd0);
    chk("mid_rst_rd_data", 32'(reg_rd_data), 32'd0);
    chk("mid_rst_rd_valid", 32'(reg_rd_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = vcnt;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_valid", 32'(vcnt - v0), 32'd0);
    push(24'hABC123);
    read_chk("post_rst_b0", 8'hAB, 3, 1);
    read_chk("post_rst_b1", 8'hC1, 1, 0);
    read_chk("post_rst_b2", 8'h20 | MK, 1, 0);

    chk("read_en_single_cycle", 32'(pw_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_data_reader.md
# fifo_data_reader

Register-side drain for the sample FIFO. It serves bus byte reads of the FIFO_DATA and FIFO_ENTRIES registers. On each FIFO_DATA frame it pops one 24-bit entry through the FIFO's edge-triggered read strobe. It returns the entry as three bytes, MSB first, with status bits inserted in the low nibble. It sits between the register/SPI byte engine and the synchronous sample FIFO.

## Interface
Parameters:
- DATA_WIDTH, 24, FIFO word width; the sample occupies [23:4].
- DEPTH, 16, FIFO depth; also the width of `fifo_sample_num`.
- FIFO_DATA_ADDR, 8'h11, register address of FIFO_DATA.
- FIFO_ENTRIES_ADDR, 8'h05, register address of FIFO_ENTRIES.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reg_rd_req  in  1  one-cycle byte-read strobe.
- reg_rd_addr  in  8  register address, qualified by `reg_rd_req`.
- reg_burst_end  in  1  one-cycle strobe marking chip-select deassert; ends the current frame.
- fifo_empty  in  1  FIFO empty flag.
- fifo_reg_data  in  DATA_WIDTH  FIFO read data register.
- fifo_sample_num  in  DEPTH  FIFO occupancy.
- reg_fifo_read_en  out  1  pop strobe to the FIFO; the FIFO acts on its rising edge.
- reg_rd_data  out  8  returned byte.
- reg_rd_valid  out  1  one-cycle qualifier for `reg_rd_data`.
- busy  out  1  high while a pop is in flight.

## Operation
- FSM states: IDLE, POP, WAIT, CAP.
- Byte index `byte_idx` ∈ {0,1,2}; it advances on each served FIFO_DATA byte and wraps from 2 to 0.
- A 24-bit hold register `hold` holds the current entry.
- FIFO_DATA request, `byte_idx`==0, `fifo_empty`==0:
  - Transitions: IDLE→POP→WAIT→CAP→IDLE.
  - `reg_fifo_read_en` is high only in POP.
  - In CAP: `hold` ← {`fifo_reg_data`[23:4], 2'b00, 1'b0, marker}.
  - In CAP: `reg_rd_data` ← `hold`[23:16] of the new entry.
- FIFO_DATA request, `byte_idx`==0, `fifo_empty`==1:
  - No pop; `hold` ← 24'h000002 (empty indicator in bit 1).
  - Byte served directly from IDLE.
- FIFO_DATA request, `byte_idx`==1 or 2: serve `hold`[15:8] or `hold`[7:0] respectively; no pop.
- FIFO_ENTRIES request: return `fifo_sample_num`, saturated to 8'hFF when any bit above bit 7 is set. `byte_idx` is unchanged.
- Any other address: ignored; no `reg_rd_valid`.
- `reg_rd_req` while `busy`: dropped.
- `reg_burst_end`: `byte_idx` ← 0.
  - An in-flight pop still completes and returns its byte.
  - After that byte, `byte_idx` remains 0.
- `reg_burst_end` and `reg_rd_req` in the same cycle: the request is decoded with `byte_idx` = 0.
- Low nibble of every entry: bits [3:2] = 0; bit 1 = empty indicator; bit 0 = axis marker (see Configuration).

## Timing
- Reset values:
  - `reg_fifo_read_en`=0, `reg_rd_data`=8'h00, `reg_rd_valid`=0, `busy`=0.
  - FSM=IDLE, `byte_idx`=0, `hold`=0, axis counter=0.
- Request sampled at edge N, pop path:
  - `reg_fifo_read_en` high from N to N+1.
  - The FIFO registers the pop at N+1 and loads its data register at N+2.
  - CAP samples at N+3; `reg_rd_valid` is high for the single cycle after N+3.
  - `busy` is high from N to N+3.
- Request sampled at edge N, all other served reads: `reg_rd_valid` is high for the single cycle after N+1.
- `reg_fifo_read_en` is always a single-cycle pulse followed by at least 2 low cycles, which guarantees a fresh rising edge per pop.
- Reset mid-pop: all state returns to reset values at once; no `reg_rd_valid` is emitted for the aborted request.
- `fifo_reg_data` is used only in CAP; the FIFO's own data-valid output is not used.

## Configuration
- Macro: `FIFO_AXIS_MARKER_EN`.
- Defined:
  - A 2-bit axis counter cycles 0→1→2→0 on each successful pop; `reg_burst_end` does not reset it.
  - marker = (counter==0, sampled before the increment).
  - Empty reads do not advance the counter.
- Undefined: no counter; marker bit 0 is always 0.

## Test plan
- FIFO holds 20'hABCDE, burst of 3 FIFO_DATA reads:
  - Bytes are 8'hAB, 8'hCD, 8'hE1 with marker; 8'hE0 without marker.
  - Exactly one `reg_fifo_read_en` pulse.
  - First `reg_rd_valid` at N+3.
- Empty FIFO, 3 FIFO_DATA reads → bytes 00, 00, 02; `reg_fifo_read_en` never asserts.
- Three entries popped in three frames, marker enabled → bit 0 of the third byte of each frame is 1, 0, 0; a fourth pop gives 1.
- `fifo_sample_num`=16 then 16'h0123 → FIFO_ENTRIES reads return 8'h10 then 8'hFF (saturated); `byte_idx` is unchanged.
- `reg_burst_end` after byte 1, then a new FIFO_DATA read → a new pop occurs and returns byte 0 of the next entry.
- Request during `busy` → no extra `reg_rd_valid`.
- `rst_n` low during WAIT → all outputs return to reset values; no `reg_rd_valid` follows.
